nmi_arb: RTL and testbench

NMI_ARB -- requirements
Module: nmi_arb

---
 rtl/nmi_arb_if.sv | 23 ++
 rtl/nmi_arb.sv | 177 +++++++++++++++++
 tb/tb_nmi_arb.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nmi_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : nmi_if
// Description : Native memory interface bundle shared by the NMI masters,
//               the arbiter and the downstream peripheral decoder.
//               Signals: valid, addr[31:0], wdata[31:0], wstrb[3:0] flow from
//               master to slave; ready and rdata[31:0] flow back.
//               modport master : drives the request, receives the response.
//               modport slave  : receives the request, drives the response.
// Revision    : 1.0 - initial release
// ============================================================================
interface nmi_if;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;

  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface
`default_nettype wire

// File: rtl/nmi_arb.sv
`default_nettype none
// ============================================================================
// Module      : nmi_arb
// Description : Two-master round-robin arbiter for the NMI bus. One
//               transaction is in flight at a time; the master served last
//               gets the lower priority when both request together.
// Ports       : clk_i     - clock, rising edge
//               rst_i     - asynchronous active-high reset
//               m0        - master 0 (CPU), nmi_if.slave
//               m1        - master 1 (DMA), nmi_if.slave
//               s         - downstream port, nmi_if.master
//               gnt_o     - one-hot grant (bit0=m0, bit1=m1), 00 when idle
//               err_clr_i - pulse clearing err_o
//               err_o     - sticky timeout flag
// Options     : `define NMI_ARB_TIMEOUT_EN to build in the transaction
//               timeout (TIMEOUT_CYC cycles). Without it err_o is tied low
//               and a transaction may wait for s.ready indefinitely.
// Revision    : 1.0 - initial release
// ============================================================================
module nmi_arb #(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic       clk_i,
  input  logic       rst_i,
  nmi_if.slave       m0,
  nmi_if.slave       m1,
  nmi_if.master      s,
  output logic [1:0] gnt_o,
  input  logic       err_clr_i,
  output logic       err_o
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [31:0] TMO_RDATA = 32'hDEAD_BEEF;

  state_t      state_q, state_d;
  logic [1:0]  gnt_q, gnt_d;
  logic        rr_q, rr_d;      // 0: m0 wins a tie, 1: m1 wins a tie

  logic        busy;
  logic        g_valid;
  logic [31:0] g_addr;
  logic [31:0] g_wdata;
  logic [3:0]  g_wstrb;
  logic [31:0] g_rdata;
  logic        g_ready;
  logic        done;
  logic        abort;
  logic        tmo_hit;

`ifdef NMI_ARB_TIMEOUT_EN
  localparam int              CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // A slave answering in the last allowed cycle still completes normally.
  assign tmo_hit = busy && g_valid && !s.ready && (cnt_q == CNT_LAST);
  assign err_o   = err_q;
`else
  logic unused_cfg;
  localparam int unused_tmo_cyc = TIMEOUT_CYC;

  assign unused_cfg = err_clr_i;
  assign tmo_hit    = 1'b0;
  assign err_o      = 1'b0;
`endif

  assign busy = (state_q == ST_BUSY);

  // Request mux; gnt_q is zero in IDLE so every consumer is also gated by busy.
  assign g_valid = gnt_q[1] ? m1.valid : m0.valid;
  assign g_addr  = gnt_q[1] ? m1.addr  : m0.addr;
  assign g_wdata = gnt_q[1] ? m1.wdata : m0.wdata;
  assign g_wstrb = gnt_q[1] ? m1.wstrb : m0.wstrb;

  // Valid dropped by the granted master ends the transaction without a
  // completion, even if the slave happens to raise ready in that cycle.
  assign abort = busy && !g_valid;
  assign done  = busy && g_valid && s.ready;

  assign s.valid = busy && g_valid && !tmo_hit;
  assign s.addr  = busy ? g_addr  : 32'h0;
  assign s.wdata = busy ? g_wdata : 32'h0;
  assign s.wstrb = busy ? g_wstrb : 4'h0;

  assign g_ready = done || tmo_hit;
  assign g_rdata = tmo_hit ? TMO_RDATA : s.rdata;

  assign m0.ready = gnt_q[0] && g_ready;
  assign m0.rdata = gnt_q[0] ? g_rdata : 32'h0;
  assign m1.ready = gnt_q[1] && g_ready;
  assign m1.rdata = gnt_q[1] ? g_rdata : 32'h0;

  assign gnt_o = gnt_q;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;

    case (state_q)
      ST_IDLE: begin
        if (m0.valid || m1.valid) begin
          state_d = ST_BUSY;
          if (m0.valid && m1.valid) begin
            gnt_d = rr_q ? 2'b10 : 2'b01;
          end else if (m1.valid) begin
            gnt_d = 2'b10;
          end else begin
            gnt_d = 2'b01;
          end
        end
      end
      ST_BUSY: begin
        if (abort) begin
          state_d = ST_IDLE;
          gnt_d   = 2'b00;
        end else if (done || tmo_hit) begin
          state_d = ST_IDLE;
          gnt_d   = 2'b00;
          // Served master drops to lowest priority: point at the other one.
          rr_d    = gnt_q[0];
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 2'b00;
      end
    endcase

`ifdef NMI_ARB_TIMEOUT_EN
    cnt_d = cnt_q;
    if (!busy) begin
      cnt_d = '0;
    end else if (!s.ready && !tmo_hit) begin
      cnt_d = cnt_q + 1'b1;
    end

    // Set takes precedence over a coincident clear.
    err_d = err_q;
    if (err_clr_i) begin
      err_d = 1'b0;
    end
    if (tmo_hit) begin
      err_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      gnt_q   <= 2'b00;
      rr_q    <= 1'b0;
`ifdef NMI_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
`ifdef NMI_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nmi_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_nmi_arb
// Description : Directed self-checking bench for nmi_arb. A cycle-by-cycle
//               vector table covers single-master, round-robin, mid-busy
//               request and abort traffic; hand-written sequences cover
//               reset during a transfer and the timeout behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nmi_arb;

  localparam logic [31:0] A0 = 32'h1000_0100;
  localparam logic [31:0] A1 = 32'h2000_0200;
  localparam logic [31:0] W0 = 32'h5A5A_0000;
  localparam logic [31:0] W1 = 32'hA5A5_A5A5;
  localparam logic [3:0]  S0 = 4'h0;
  localparam logic [3:0]  S1 = 4'hF;
  localparam int          NV = 31;

  logic       clk;
  logic       rst;
  logic       err_clr;
  logic       err;
  logic [1:0] gnt;

  int total = 0;
  int bad   = 0;

  nmi_if m0_if ();
  nmi_if m1_if ();
  nmi_if s_if ();

  nmi_arb #(.TIMEOUT_CYC(16)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .m0        (m0_if),
    .m1        (m1_if),
    .s         (s_if),
    .gnt_o     (gnt),
    .err_clr_i (err_clr),
    .err_o     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        m0v;
    logic        m1v;
    logic        sr;
    logic [31:0] rd;
    logic [1:0]  gnt;
    logic        sv;
    logic [31:0] swd;
    logic        m0r;
    logic        m1r;
    logic [31:0] m0rd;
    logic [31:0] m1rd;
  } vec_t;

  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    m0_if.valid = 1'b0;
    m1_if.valid = 1'b0;
    s_if.ready  = 1'b0;
    s_if.rdata  = 32'h0;
    err_clr     = 1'b0;
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] ea;
    logic [3:0]  es;

    //            rst   m0v   m1v   sr    rd             gnt    sv    swd  m0r   m1r   m0rd           m1rd
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,       32'h0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         2'b01, 1'b1, W0, 1'b0, 1'b0, 32'h0,          32'h0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         2'b01, 1'b1, W0, 1'b0, 1'b0, 32'h0,          32'h0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         2'b01, 1'b1, W0, 1'b0, 1'b0, 32'h0,          32'h0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h1234_5678, 2'b01, 1'b1, W0, 1'b1, 1'b0, 32'h1234_5678,  32'h0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,       32'h0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,       32'h0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,       32'h0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         2'b01, 1'b1, W0, 1'b0, 1'b0, 32'h0,          32'h0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_1111, 2'b01, 1'b1, W0, 1'b1, 1'b0, 32'h0000_1111,  32'h0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,       32'h0};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         2'b10, 1'b1, W1, 1'b0, 1'b0, 32'h0,          32'h0};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_2222, 2'b10, 1'b1, W1, 1'b0, 1'b1, 32'h0,          32'h0000_2222};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,       32'h0};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         2'b01, 1'b1, W0, 1'b0, 1'b0, 32'h0,          32'h0};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_3333, 2'b01, 1'b1, W0, 1'b1, 1'b0, 32'h0000_3333,  32'h0};
    vecs[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,       32'h0};
    vecs[17] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         2'b10, 1'b1, W1, 1'b0, 1'b0, 32'h0,          32'h0};
    vecs[18] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_4444, 2'b10, 1'b1, W1, 1'b0, 1'b1, 32'h0,          32'h0000_4444};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,       32'h0};
    vecs[20] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,       32'h0};
    vecs[21] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         2'b01, 1'b1, W0, 1'b0, 1'b0, 32'h0,          32'h0};
    vecs[22] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_5555, 2'b01, 1'b1, W0, 1'b1, 1'b0, 32'h0000_5555,  32'h0};
    vecs[23] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,       32'h0};
    vecs[24] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         2'b10, 1'b1, W1, 1'b0, 1'b0, 32'h0,          32'h0};
    vecs[25] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         2'b10, 1'b0, W1, 1'b0, 1'b0, 32'h0,          32'h0};
    vecs[26] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,       32'h0};
    vecs[27] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,       32'h0};
    vecs[28] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_6666, 2'b10, 1'b1, W1, 1'b0, 1'b1, 32'h0,          32'h0000_6666};
    vecs[29] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,       32'h0};
    vecs[30] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         2'b01, 1'b1, W0, 1'b0, 1'b0, 32'h0,          32'h0};

    m0_if.addr  = A0;
    m0_if.wdata = W0;
    m0_if.wstrb = S0;
    m1_if.addr  = A1;
    m1_if.wdata = W1;
    m1_if.wstrb = S1;

    // ---------------- reset state ----------------
    rst         = 1'b1;
    m0_if.valid = 1'b0;
    m1_if.valid = 1'b0;
    s_if.ready  = 1'b0;
    s_if.rdata  = 32'h0;
    err_clr     = 1'b0;
    @(negedge clk);
    chk("reset gnt",      32'(gnt), 32'h0);
    chk("reset s.valid",  32'(s_if.valid), 32'h0);
    chk("reset err",      32'(err), 32'h0);
    chk("reset m0.ready", 32'(m0_if.ready), 32'h0);
    chk("reset m1.ready", 32'(m1_if.ready), 32'h0);
    next_cycle();
    rst = 1'b0;

    // ---------------- vector table ----------------
    for (int k = 0; k < NV; k++) begin
      rst         = vecs[k].rst;
      m0_if.valid = vecs[k].m0v;
      m1_if.valid = vecs[k].m1v;
      s_if.ready  = vecs[k].sr;
      s_if.rdata  = vecs[k].rd;
      @(negedge clk);
      ea = (vecs[k].gnt == 2'b01) ? A0 : (vecs[k].gnt == 2'b10) ? A1 : 32'h0;
      es = (vecs[k].gnt == 2'b10) ? S1 : S0;
      chk($sformatf("v%0d gnt", k),      32'(gnt),          32'(vecs[k].gnt));
      chk($sformatf("v%0d s.valid", k),  32'(s_if.valid),   32'(vecs[k].sv));
      chk($sformatf("v%0d s.addr", k),   s_if.addr,         ea);
      chk($sformatf("v%0d s.wdata", k),  s_if.wdata,        vecs[k].swd);
      chk($sformatf("v%0d s.wstrb", k),  32'(s_if.wstrb),   32'(es));
      chk($sformatf("v%0d m0.ready", k), 32'(m0_if.ready),  32'(vecs[k].m0r));
      chk($sformatf("v%0d m1.ready", k), 32'(m1_if.ready),  32'(vecs[k].m1r));
      chk($sformatf("v%0d m0.rdata", k), m0_if.rdata,       vecs[k].m0rd);
      chk($sformatf("v%0d m1.rdata", k), m1_if.rdata,       vecs[k].m1rd);
      chk($sformatf("v%0d err", k),      32'(err),          32'h0);
      next_cycle();
    end

    // ---------------- reset while m1 is granted ----------------
    apply_reset();
    m0_if.valid = 1'b1;
    next_cycle();                       // m0 busy
    s_if.ready = 1'b1;
    @(negedge clk);
    chk("rst-seq m0 done", 32'(m0_if.ready), 32'h1);
    next_cycle();
    s_if.ready  = 1'b0;
    m0_if.valid = 1'b0;
    m1_if.valid = 1'b1;                 // idle; m1 now has priority
    next_cycle();
    @(negedge clk);
    chk("rst-seq m1 granted", 32'(gnt), 32'h2);
    #2;
    rst = 1'b1;                         // asynchronous, between edges
    #1;
    chk("rst-seq gnt cleared",    32'(gnt), 32'h0);
    chk("rst-seq s.valid low",    32'(s_if.valid), 32'h0);
    chk("rst-seq err low",        32'(err), 32'h0);
    chk("rst-seq m1.ready low",   32'(m1_if.ready), 32'h0);
    m0_if.valid = 1'b1;
    m1_if.valid = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rst-seq idle after release", 32'(gnt), 32'h0);
    next_cycle();
    @(negedge clk);
    chk("rst-seq m0 first", 32'(gnt), 32'h1);
    next_cycle();

`ifdef NMI_ARB_TIMEOUT_EN
    // ---------------- timeout, slave never answers ----------------
    apply_reset();
    m0_if.valid = 1'b1;
    next_cycle();
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c < 16) begin
        chk($sformatf("tmo c%0d m0.ready", c), 32'(m0_if.ready), 32'h0);
        chk($sformatf("tmo c%0d s.valid", c),  32'(s_if.valid),  32'h1);
      end else begin
        chk("tmo m0.ready",  32'(m0_if.ready), 32'h1);
        chk("tmo m0.rdata",  m0_if.rdata,      32'hDEAD_BEEF);
        chk("tmo s.valid",   32'(s_if.valid),  32'h0);
        chk("tmo m1.ready",  32'(m1_if.ready), 32'h0);
      end
      next_cycle();
    end
    m0_if.valid = 1'b0;
    @(negedge clk);
    chk("tmo err set", 32'(err), 32'h1);
    chk("tmo idle",    32'(gnt), 32'h0);
    next_cycle();
    @(negedge clk);
    chk("tmo err sticky", 32'(err), 32'h1);
    next_cycle();
    err_clr = 1'b1;
    @(negedge clk);
    chk("tmo err before clear", 32'(err), 32'h1);
    next_cycle();
    err_clr = 1'b0;
    @(negedge clk);
    chk("tmo err cleared", 32'(err), 32'h0);
    next_cycle();

    // ---------------- ready in the timeout cycle wins ----------------
    m0_if.valid = 1'b1;
    next_cycle();
    repeat (15) next_cycle();
    s_if.ready = 1'b1;
    s_if.rdata = 32'h0000_7777;
    @(negedge clk);
    chk("late ready m0.ready", 32'(m0_if.ready), 32'h1);
    chk("late ready m0.rdata", m0_if.rdata,      32'h0000_7777);
    chk("late ready s.valid",  32'(s_if.valid),  32'h1);
    next_cycle();
    s_if.ready  = 1'b0;
    m0_if.valid = 1'b0;
    @(negedge clk);
    chk("late ready no err", 32'(err), 32'h0);
    chk("late ready idle",   32'(gnt), 32'h0);
    next_cycle();
`else
    // ---------------- no timeout: busy waits indefinitely ----------------
    apply_reset();
    m0_if.valid = 1'b1;
    next_cycle();
    err_clr = 1'b1;
    next_cycle();
    err_clr = 1'b0;
    repeat (40) next_cycle();
    @(negedge clk);
    chk("no-tmo still granted", 32'(gnt),         32'h1);
    chk("no-tmo s.valid",       32'(s_if.valid),  32'h1);
    chk("no-tmo m0.ready",      32'(m0_if.ready), 32'h0);
    chk("no-tmo err",           32'(err),         32'h0);
    next_cycle();
    s_if.ready = 1'b1;
    s_if.rdata = 32'h0000_7777;
    @(negedge clk);
    chk("no-tmo completion ready", 32'(m0_if.ready), 32'h1);
    chk("no-tmo completion rdata", m0_if.rdata,      32'h0000_7777);
    next_cycle();
    s_if.ready  = 1'b0;
    m0_if.valid = 1'b0;
    @(negedge clk);
    chk("no-tmo idle", 32'(gnt), 32'h0);
    next_cycle();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
